board_store: RTL and testbench
==============================

Name: board_store

Overview:
- Parametrised board memory that replaces the inline board array and initial-layout block in the top level.
- Holds the piece at every square and fills the start position one square per cycle.
- Commits a move atomically: writes source and destination in the same cycle.
- Keeps a bounded undo history of committed moves.
- Sits between chess_logic (move commit, undo, read) and display/debug consumers (flat board bus).

Parameters:
ROWS, 8, board rows, >= 4
COLS, 8, board columns, >= 8; columns 8 and above of back ranks start empty
UNDO_DEPTH, 16, undo history entries, power of two, >= 2

Ports:
CLK  in  1  game-logic clock
RESET_N  in  1  asynchronous, active-low reset
init_req  in  1  one-cycle pulse: reload start position and clear history
init_busy  out  1  high while the layout is being written
move_valid  in  1  move commit request
move_ready  out  1  = !init_busy
move_src  in  ADDR_W  source square, row*COLS+col
move_dst  in  ADDR_W  destination square
move_piece  in  4  piece written to the destination (allows promotion)
undo_req  in  1  one-cycle pulse: revert the newest history entry
undo_err  out  1  one-cycle pulse: undo rejected
undo_count  out  clog2(UNDO_DEPTH)+1  valid history entries
rd_addr  in  ADDR_W  random read address
rd_piece  out  4  combinational board[rd_addr]
board_flat  out  4*ROWS*COLS  square i at bits [4i+3:4i]
last_src, last_dst  out  ADDR_W  squares of the newest history entry, 0 when the history is empty

Behaviour:
- ADDR_W = clog2(ROWS*COLS). Piece = {color, type[2:0]}. Empty = 4'b0000.
- Reset (RESET_N low, asynchronous):
  - all squares = 0, history cleared, undo_count = 0, undo_err = 0, last_src = last_dst = 0.
  - init_busy = 1, so init starts automatically on the first clock after release.
- Init sequencer, states IDLE and FILL:
  - FILL writes square init_ptr each cycle, pointer 0 to ROWS*COLS-1, then goes to IDLE. Fill takes ROWS*COLS cycles.
  - Row 0: black back rank. Row 1: black pawns. Row ROWS-2: white pawns. Row ROWS-1: white back rank. All other rows empty.
  - Back rank, columns 0..7: R N B Q K B N R. Columns >= 8: empty.
  - init_req in IDLE: enter FILL next cycle and clear history.
  - init_req during FILL: restart the pointer at 0.
- Move commit, when move_valid && move_ready:
  - Same edge: board[dst] <= move_piece, board[src] <= EMPTY.
  - Same edge: push the entry {src, dst, old_src_piece, old_dst_piece}.
  - src == dst: the destination write wins, board[dst] = move_piece. Both old pieces recorded equal.
  - move_valid while !move_ready: ignored, no side effect.
- History is a circular buffer with a write pointer and a count.
  - Push when count == UNDO_DEPTH: overwrite the oldest entry; count stays at UNDO_DEPTH.
  - Pointer arithmetic is modulo UNDO_DEPTH.
- Undo, on an undo_req pulse:
  - Accepted when count > 0, not busy, and no move commit in the same cycle.
  - Same edge: board[src] <= old_src, then board[dst] <= old_dst. If src == dst, old_dst is applied last.
  - Pop: pointer--, count--.
  - last_src/last_dst then show the new newest entry, or 0 if none.
- Undo rejection: undo_err pulses high for exactly one cycle (registered, next edge) with no state change when any of these holds:
  - count == 0
  - init_busy
  - a move is committed in the same cycle (a move beats an undo)
- rd_piece and board_flat reflect the registered board state. Latency is one cycle from a commit edge.
- Reset mid-FILL or mid-operation: everything returns to the reset state above.

Decomposition:
- Package chess_pkg:
  - PIECE_* type codes, COLOR_WHITE/COLOR_BLACK, EMPTY.
  - Piece-width localparam.
  - Function start_piece(row, col, ROWS) returning the layout code.
- One sub-module: undo_stack. It holds the parametrised UNDO_DEPTH circular LIFO with push, pop, count and top output; entry width 2*ADDR_W+8.
- The board array, commit/undo write logic and init FSM stay in board_store.

Test Plan:
- Reset release, default parameters: init_busy high for 64 cycles, then low.
  - Required: board_flat[3:0] = 4'b0100, square 4 = 4'b0110, square 60 = 4'b1110, square 8 = 4'b0001, square 52 = 4'b1001, squares 16..47 = 0, undo_count = 0.
- Commit src=52, dst=36, piece 4'b1001.
  - Required, next cycle: rd_piece(36) = 4'b1001, rd_piece(52) = 0, undo_count = 1, last_src = 52, last_dst = 36.
- Capture 36->27 (27 holds 4'b0001), then two undo pulses.
  - After the first undo: 27 = 4'b0001, 36 = 4'b1001.
  - After the second: 52 = 4'b1001, 36 = 0, count = 0.
  - A third undo: undo_err high for exactly 1 cycle, board unchanged.
- UNDO_DEPTH=4: commit 6 distinct moves.
  - Required: count saturates at 4; 4 undos revert moves 6..3; a 5th undo raises undo_err; moves 1 and 2 remain applied.
- move_valid and undo_req in the same cycle with count = 1.
  - Required: the move is committed, undo_err pulses, count = 2.
- init_req after 3 moves, and a move_valid during FILL.
  - Required: move_ready = 0 and the move is ignored; after 64 cycles the start layout is restored and count = 0.
- ROWS=10, COLS=10.
  - Required: fill takes 100 cycles, white pawns in row 8, squares 8 and 9 empty.
- RESET_N low mid-FILL.
  - Required: outputs drop to reset values immediately.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess definitions for the board store.
// - Piece encoding is {color, type[2:0]}; 4'b0000 is an empty square.
// - start_piece() returns the start-position code for any (row, col) on a
//   board with the given number of rows. Black sits on rows 0/1 and white
//   on the last two rows. Back-rank columns 8 and above start empty.
package chess_pkg;

  localparam int PIECE_W = 4;
  typedef logic [PIECE_W-1:0] piece_t;

  localparam logic [2:0] PIECE_NONE   = 3'd0;
  localparam logic [2:0] PIECE_PAWN   = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT = 3'd2;
  localparam logic [2:0] PIECE_BISHOP = 3'd3;
  localparam logic [2:0] PIECE_ROOK   = 3'd4;
  localparam logic [2:0] PIECE_QUEEN  = 3'd5;
  localparam logic [2:0] PIECE_KING   = 3'd6;

  localparam logic COLOR_WHITE = 1'b1;
  localparam logic COLOR_BLACK = 1'b0;

  localparam piece_t EMPTY = '0;

  typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} init_state_t;

  function automatic piece_t start_piece(input int row, input int col, input int rows);
    logic       color;
    logic [2:0] kind;
    color = (row >= rows - 2) ? COLOR_WHITE : COLOR_BLACK;
    kind  = PIECE_NONE;
    if (row == 1 || row == rows - 2) begin
      kind = PIECE_PAWN;
    end else if (row == 0 || row == rows - 1) begin
      case (col)
        0, 7:    kind = PIECE_ROOK;
        1, 6:    kind = PIECE_KNIGHT;
        2, 5:    kind = PIECE_BISHOP;
        3:       kind = PIECE_QUEEN;
        4:       kind = PIECE_KING;
        default: kind = PIECE_NONE;
      endcase
    end
    start_piece = (kind == PIECE_NONE) ? EMPTY : {color, kind};
  endfunction

endpackage

// File: rtl/undo_stack.sv
// Circular LIFO holding the most recent DEPTH committed moves.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        drop all entries (takes priority over push/pop)
//   push         append push_entry; when full the oldest entry is overwritten
//   pop          drop the newest entry (ignored when empty)
//   count        number of valid entries, 0..DEPTH
//   top          newest entry; only meaningful while count != 0
module undo_stack #(
  parameter  int DEPTH   = 16,
  parameter  int ENTRY_W = 20,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] push_entry,
  output logic [CNT_W-1:0]   count,
  output logic [ENTRY_W-1:0] top
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wptr;

  // wptr is the next free slot. DEPTH is a power of two, so the natural
  // wrap of the pointer gives the modulo arithmetic, and pushing while full
  // lands on the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      count <= '0;
    end else if (push) begin
      wptr <= wptr + 1'b1;
      if (count != FULL) count <= count + 1'b1;
    end else if (pop && count != '0) begin
      wptr  <= wptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= push_entry;
  end

  assign top = mem[wptr - 1'b1];

endmodule

// File: rtl/board_store.sv
// Board memory for the chess game logic.
// Holds one piece per square, refills the start position one square per
// cycle after reset or init_req, commits moves atomically (source cleared
// and destination written on the same edge) and reverts them from a
// bounded undo history.
// Ports:
//   CLK, RESET_N           clock, asynchronous active-low reset
//   init_req / init_busy   reload request pulse / fill in progress
//   move_valid/move_ready  move commit handshake (ready = !init_busy)
//   move_src/dst/piece     squares (row*COLS+col) and piece for destination
//   undo_req / undo_err    undo pulse / one-cycle rejection pulse
//   undo_count             valid history entries
//   rd_addr / rd_piece     combinational random read
//   board_flat             all squares, square i at [4i+3:4i]
//   last_src / last_dst    squares of newest history entry, 0 when empty
module board_store
  import chess_pkg::*;
#(
  parameter  int ROWS       = 8,
  parameter  int COLS       = 8,
  parameter  int UNDO_DEPTH = 16,
  localparam int NSQ        = ROWS * COLS,
  localparam int ADDR_W     = $clog2(ROWS * COLS),
  localparam int CNT_W      = $clog2(UNDO_DEPTH) + 1
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     init_req,
  output logic                     init_busy,
  input  logic                     move_valid,
  output logic                     move_ready,
  input  logic [ADDR_W-1:0]        move_src,
  input  logic [ADDR_W-1:0]        move_dst,
  input  logic [PIECE_W-1:0]       move_piece,
  input  logic                     undo_req,
  output logic                     undo_err,
  output logic [CNT_W-1:0]         undo_count,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [PIECE_W-1:0]       rd_piece,
  output logic [PIECE_W*NSQ-1:0]   board_flat,
  output logic [ADDR_W-1:0]        last_src,
  output logic [ADDR_W-1:0]        last_dst
);

  localparam int                ENTRY_W = 2 * ADDR_W + 2 * PIECE_W;
  localparam logic [ADDR_W-1:0] LAST_SQ = ADDR_W'(NSQ - 1);
  localparam logic [ADDR_W:0]   NSQ_A   = (ADDR_W + 1)'(NSQ);

  logic [NSQ-1:0][PIECE_W-1:0] board;
  init_state_t                 state, state_nxt;
  logic [ADDR_W-1:0]           init_ptr;
  logic                        fill_last, commit, undo_ok;
  logic                        src_ok, dst_ok, rd_ok, top_src_ok, top_dst_ok;
  piece_t                      old_src, old_dst, fill_piece;
  logic [CNT_W-1:0]            count;
  logic [ENTRY_W-1:0]          top, push_entry;
  logic [ADDR_W-1:0]           top_src, top_dst;
  piece_t                      top_old_src, top_old_dst;

  // Address fields can exceed the square count when ROWS*COLS is not a
  // power of two; such addresses read as empty and are never written.
  assign src_ok     = {1'b0, move_src} < NSQ_A;
  assign dst_ok     = {1'b0, move_dst} < NSQ_A;
  assign rd_ok      = {1'b0, rd_addr}  < NSQ_A;
  assign top_src_ok = {1'b0, top_src}  < NSQ_A;
  assign top_dst_ok = {1'b0, top_dst}  < NSQ_A;

  assign old_src = src_ok ? board[move_src] : EMPTY;
  assign old_dst = dst_ok ? board[move_dst] : EMPTY;

  assign fill_last  = (init_ptr == LAST_SQ);
  assign move_ready = !init_busy;
  assign commit     = move_valid && move_ready;
  // A move in the same cycle beats an undo.
  assign undo_ok    = undo_req && !init_busy && !commit && (count != '0);

  assign push_entry = {move_src, move_dst, old_src, old_dst};
  assign {top_src, top_dst, top_old_src, top_old_dst} = top;

  always_comb begin
    fill_piece = start_piece(int'(init_ptr) / COLS, int'(init_ptr) % COLS, ROWS);
  end

  // Init sequencer: state register / next state / outputs.
  // Reset lands in FILL so the layout loads right after release.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_FILL;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (init_req) state_nxt = ST_FILL;
      ST_FILL: if (!init_req && fill_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    init_busy = (state == ST_FILL);
  end

  // Fill pointer rests at 0 outside FILL; init_req during FILL restarts it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                                        init_ptr <= '0;
    else if (state == ST_FILL && !init_req && !fill_last) init_ptr <= init_ptr + 1'b1;
    else                                                 init_ptr <= '0;
  end

  // Board writes. In both commit and undo the destination write comes last,
  // so it wins when source and destination are the same square.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      board <= '0;
    end else if (init_busy) begin
      board[init_ptr] <= fill_piece;
    end else if (commit) begin
      if (src_ok) board[move_src] <= EMPTY;
      if (dst_ok) board[move_dst] <= move_piece;
    end else if (undo_ok) begin
      if (top_src_ok) board[top_src] <= top_old_src;
      if (top_dst_ok) board[top_dst] <= top_old_dst;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) undo_err <= 1'b0;
    else          undo_err <= undo_req && !undo_ok;
  end

  undo_stack #(
    .DEPTH   (UNDO_DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_undo_stack (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .clear      (init_req),
    .push       (commit),
    .pop        (undo_ok),
    .push_entry (push_entry),
    .count      (count),
    .top        (top)
  );

  assign undo_count = count;
  assign last_src   = (count == '0) ? '0 : top_src;
  assign last_dst   = (count == '0) ? '0 : top_dst;
  assign rd_piece   = rd_ok ? board[rd_addr] : EMPTY;
  assign board_flat = board;

endmodule

// File: tb/tb_board_store.sv
// Bench for board_store: three instances (8x8 depth 16, 8x8 depth 4,
// 10x10 depth 16) checked against a list-based reference model.
module tb_board_store;

  logic CLK = 1'b0;
  logic RESET_N = 1'b1;
  always #5 CLK = ~CLK;

  // Instances 0 and 1: 8x8 boards
  logic        ir [2], mv [2], ur [2];
  logic [5:0]  ms [2], md [2], ra [2];
  logic [3:0]  mp [2];
  logic        busy [2], rdy [2], uerr [2];
  logic [3:0]  rp [2];
  logic [255:0] bf [2];
  logic [5:0]  ls [2], ld [2];
  logic [4:0]  ucnt0;
  logic [2:0]  ucnt1;
  // Instance 2: 10x10 board
  logic        ir2, mv2, ur2, busy2, rdy2, uerr2;
  logic [6:0]  ms2, md2, ra2, ls2, ld2;
  logic [3:0]  mp2, rp2;
  logic [4:0]  ucnt2;
  logic [399:0] bf2;

  board_store dut0 (.CLK(CLK), .RESET_N(RESET_N), .init_req(ir[0]), .init_busy(busy[0]),
    .move_valid(mv[0]), .move_ready(rdy[0]), .move_src(ms[0]), .move_dst(md[0]),
    .move_piece(mp[0]), .undo_req(ur[0]), .undo_err(uerr[0]), .undo_count(ucnt0),
    .rd_addr(ra[0]), .rd_piece(rp[0]), .board_flat(bf[0]), .last_src(ls[0]), .last_dst(ld[0]));

  board_store #(.UNDO_DEPTH(4)) dut1 (.CLK(CLK), .RESET_N(RESET_N), .init_req(ir[1]),
    .init_busy(busy[1]), .move_valid(mv[1]), .move_ready(rdy[1]), .move_src(ms[1]),
    .move_dst(md[1]), .move_piece(mp[1]), .undo_req(ur[1]), .undo_err(uerr[1]),
    .undo_count(ucnt1), .rd_addr(ra[1]), .rd_piece(rp[1]), .board_flat(bf[1]),
    .last_src(ls[1]), .last_dst(ld[1]));

  board_store #(.ROWS(10), .COLS(10)) dut2 (.CLK(CLK), .RESET_N(RESET_N), .init_req(ir2),
    .init_busy(busy2), .move_valid(mv2), .move_ready(rdy2), .move_src(ms2), .move_dst(md2),
    .move_piece(mp2), .undo_req(ur2), .undo_err(uerr2), .undo_count(ucnt2), .rd_addr(ra2),
    .rd_piece(rp2), .board_flat(bf2), .last_src(ls2), .last_dst(ld2));

  int checks = 0;
  int errors = 0;

  // Reference model: board contents plus an ordered list of history entries
  logic [3:0] mb  [2][64];
  int         hs  [2][16];
  int         hd  [2][16];
  logic [3:0] hos [2][16];
  logic [3:0] hod [2][16];
  int         hn  [2];
  int         depth [2];
  bit         mbusy [2];

  function automatic logic [3:0] ref_layout(input int r, input int c, input int rows);
    int kinds [8];
    int t;
    logic white;
    kinds = '{4, 2, 3, 5, 6, 3, 2, 4};
    t = 0;
    if (r == 1 || r == rows - 2) t = 1;
    else if ((r == 0 || r == rows - 1) && c < 8) t = kinds[c];
    white = (r >= rows / 2);
    return (t == 0) ? 4'b0000 : {white, 3'(t)};
  endfunction

  task automatic m_init(input int k);
    for (int i = 0; i < 64; i++) mb[k][i] = ref_layout(i / 8, i % 8, 8);
    hn[k] = 0;
  endtask

  task automatic m_move(input int k, input int s, input int d, input logic [3:0] p);
    if (hn[k] == depth[k]) begin
      for (int j = 0; j < depth[k] - 1; j++) begin
        hs[k][j] = hs[k][j+1]; hd[k][j] = hd[k][j+1];
        hos[k][j] = hos[k][j+1]; hod[k][j] = hod[k][j+1];
      end
      hn[k]--;
    end
    hs[k][hn[k]] = s; hd[k][hn[k]] = d;
    hos[k][hn[k]] = mb[k][s]; hod[k][hn[k]] = mb[k][d];
    hn[k]++;
    mb[k][s] = 4'b0000;
    mb[k][d] = p;
  endtask

  task automatic m_undo(input int k);
    hn[k]--;
    mb[k][hs[k][hn[k]]] = hos[k][hn[k]];
    mb[k][hd[k][hn[k]]] = hod[k][hn[k]];
  endtask

  function automatic logic [255:0] exp_flat(input int k);
    logic [255:0] f;
    for (int i = 0; i < 64; i++) f[4*i +: 4] = mb[k][i];
    return f;
  endfunction

  function automatic int exp_ls(input int k);
    return (hn[k] > 0) ? hs[k][hn[k]-1] : 0;
  endfunction

  function automatic int exp_ld(input int k);
    return (hn[k] > 0) ? hd[k][hn[k]-1] : 0;
  endfunction

  function automatic int get_cnt(input int k);
    return (k == 0) ? int'(ucnt0) : int'(ucnt1);
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_move(input int k, input int s, input int d, input logic [3:0] p);
    ms[k] = 6'(s); md[k] = 6'(d); mp[k] = p; mv[k] = 1'b1;
    tick();
    mv[k] = 1'b0;
    if (!mbusy[k]) m_move(k, s, d, p);
  endtask

  task automatic do_undo(input int k, output bit exp_err);
    ur[k] = 1'b1;
    tick();
    ur[k] = 1'b0;
    if (!mbusy[k] && hn[k] > 0) begin
      m_undo(k);
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic test_reset;
    int t0, t1, t2, bad;
    #1 RESET_N = 1'b0;
    #12;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (busy[k] !== 1'b1 || bf[k] !== '0 || get_cnt(k) != 0 || uerr[k] !== 1'b0 ||
          ls[k] !== 6'd0 || ld[k] !== 6'd0 || rdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst%0d: busy=%b cnt=%0d err=%b ls=%0d ld=%0d board_zero=%b, need busy=1 others 0",
                 k, busy[k], get_cnt(k), uerr[k], ls[k], ld[k], bf[k] == '0);
      end
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    t0 = -1; t1 = -1; t2 = -1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (!busy[0] && t0 < 0) t0 = n;
      if (!busy[1] && t1 < 0) t1 = n;
      if (!busy2 && t2 < 0) t2 = n;
      if (t0 > 0 && t1 > 0 && t2 > 0) break;
    end
    checks++;
    if (t0 != 64 || t1 != 64) begin
      errors++;
      $display("FAIL fill_time_8x8: got %0d/%0d cycles, need 64", t0, t1);
    end
    checks++;
    if (t2 != 100) begin
      errors++;
      $display("FAIL fill_time_10x10: got %0d cycles, need 100", t2);
    end
    m_init(0); m_init(1); mbusy[0] = 0; mbusy[1] = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bf[k] !== exp_flat(k) || get_cnt(k) != 0) begin
        errors++;
        $display("FAIL start_layout inst%0d: board %h cnt %0d, need %h cnt 0", k, bf[k], get_cnt(k), exp_flat(k));
      end
    end
    checks++;
    if (bf[0][3:0] !== 4'b0100 || bf[0][19:16] !== 4'b0110 || bf[0][243:240] !== 4'b1110 ||
        bf[0][35:32] !== 4'b0001 || bf[0][211:208] !== 4'b1001 || bf[0][191:64] !== '0) begin
      errors++;
      $display("FAIL start_squares: sq0=%b sq4=%b sq60=%b sq8=%b sq52=%b, need 0100 0110 1110 0001 1001",
               bf[0][3:0], bf[0][19:16], bf[0][243:240], bf[0][35:32], bf[0][211:208]);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) if (bf2[4*i +: 4] !== ref_layout(i / 10, i % 10, 10)) bad++;
    checks++;
    if (bad != 0 || bf2[35:32] !== 4'b0000 || bf2[39:36] !== 4'b0000) begin
      errors++;
      $display("FAIL layout_10x10: %0d squares wrong, sq8=%b sq9=%b need 0000", bad, bf2[35:32], bf2[39:36]);
    end
    ra2 = 7'd85;
    #1;
    checks++;
    if (rp2 !== 4'b1001 || ucnt2 !== 5'd0 || uerr2 !== 1'b0 || rdy2 !== 1'b1 || ls2 !== 7'd0 || ld2 !== 7'd0) begin
      errors++;
      $display("FAIL idle_10x10: rd85=%b cnt=%0d err=%b rdy=%b, need 1001 0 0 1", rp2, ucnt2, uerr2, rdy2);
    end
  endtask

  task automatic test_commit;
    logic [3:0] r36, r52;
    do_move(0, 52, 36, 4'b1001);
    ra[0] = 6'd36; #1; r36 = rp[0];
    ra[0] = 6'd52; #1; r52 = rp[0];
    checks++;
    if (r36 !== 4'b1001 || r52 !== 4'b0000) begin
      errors++;
      $display("FAIL commit_read: rd36=%b rd52=%b, need 1001 0000", r36, r52);
    end
    checks++;
    if (get_cnt(0) != 1 || ls[0] !== 6'd52 || ld[0] !== 6'd36 || bf[0] !== exp_flat(0)) begin
      errors++;
      $display("FAIL commit_history: cnt=%0d last=%0d->%0d, need 1 52->36", get_cnt(0), ls[0], ld[0]);
    end
  endtask

  task automatic test_capture_undo;
    bit e;
    do_move(0, 11, 27, 4'b0001);
    do_move(0, 36, 27, 4'b1001);
    do_undo(0, e);
    checks++;
    if (uerr[0] !== e || bf[0][111:108] !== 4'b0001 || bf[0][147:144] !== 4'b1001 || bf[0] !== exp_flat(0)) begin
      errors++;
      $display("FAIL undo_capture: err=%b sq27=%b sq36=%b, need 0 0001 1001", uerr[0], bf[0][111:108], bf[0][147:144]);
    end
    do_undo(0, e);
    checks++;
    if (uerr[0] !== e || bf[0] !== exp_flat(0) || get_cnt(0) != hn[0] || ls[0] !== 6'(exp_ls(0))) begin
      errors++;
      $display("FAIL undo_second: err=%b cnt=%0d ls=%0d, need %b %0d %0d", uerr[0], get_cnt(0), ls[0], e, hn[0], exp_ls(0));
    end
    do_undo(0, e);
    checks++;
    if (bf[0][211:208] !== 4'b1001 || bf[0][147:144] !== 4'b0000 || get_cnt(0) != 0 ||
        ls[0] !== 6'd0 || ld[0] !== 6'd0 || bf[0] !== exp_flat(0)) begin
      errors++;
      $display("FAIL undo_to_start: sq52=%b sq36=%b cnt=%0d, need 1001 0000 0", bf[0][211:208], bf[0][147:144], get_cnt(0));
    end
    do_undo(0, e);
    checks++;
    if (uerr[0] !== 1'b1 || e !== 1'b1 || bf[0] !== exp_flat(0)) begin
      errors++;
      $display("FAIL undo_empty_err: err=%b, need 1 with board unchanged", uerr[0]);
    end
    tick();
    checks++;
    if (uerr[0] !== 1'b0) begin
      errors++;
      $display("FAIL undo_err_width: err=%b one cycle later, need 0", uerr[0]);
    end
  endtask

  task automatic test_depth4;
    int s, d;
    bit e;
    for (int i = 0; i < 6; i++) begin
      s = $urandom_range(0, 63);
      d = (s + 1 + $urandom_range(0, 61)) % 64;
      do_move(1, s, d, 4'($urandom_range(1, 15)));
    end
    checks++;
    if (get_cnt(1) != 4 || bf[1] !== exp_flat(1) || ls[1] !== 6'(exp_ls(1)) || ld[1] !== 6'(exp_ld(1))) begin
      errors++;
      $display("FAIL depth4_saturate: cnt=%0d, need 4 (ls=%0d need %0d)", get_cnt(1), ls[1], exp_ls(1));
    end
    for (int i = 0; i < 4; i++) begin
      do_undo(1, e);
      checks++;
      if (uerr[1] !== e || bf[1] !== exp_flat(1) || get_cnt(1) != hn[1] || ls[1] !== 6'(exp_ls(1))) begin
        errors++;
        $display("FAIL depth4_undo%0d: err=%b cnt=%0d ls=%0d, need %b %0d %0d", i, uerr[1], get_cnt(1), ls[1], e, hn[1], exp_ls(1));
      end
    end
    do_undo(1, e);
    checks++;
    if (uerr[1] !== 1'b1 || e !== 1'b1 || bf[1] !== exp_flat(1) || get_cnt(1) != 0) begin
      errors++;
      $display("FAIL depth4_fifth_undo: err=%b cnt=%0d, need err 1 cnt 0, moves 1-2 kept", uerr[1], get_cnt(1));
    end
  endtask

  task automatic test_move_beats_undo;
    do_move(0, 12, 28, 4'b0001);
    ms[0] = 6'd51; md[0] = 6'd35; mp[0] = 4'b1001; mv[0] = 1'b1; ur[0] = 1'b1;
    tick();
    mv[0] = 1'b0; ur[0] = 1'b0;
    m_move(0, 51, 35, 4'b1001);
    checks++;
    if (uerr[0] !== 1'b1 || get_cnt(0) != 2 || bf[0] !== exp_flat(0) || ls[0] !== 6'd51 || ld[0] !== 6'd35) begin
      errors++;
      $display("FAIL move_beats_undo: err=%b cnt=%0d last=%0d->%0d, need 1 2 51->35", uerr[0], get_cnt(0), ls[0], ld[0]);
    end
  endtask

  task automatic test_random;
    int op, a;
    bit e;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      e = 1'b0;
      if (op <= 1) do_move(0, $urandom_range(0, 63), $urandom_range(0, 63), 4'($urandom_range(0, 15)));
      else if (op == 2) do_undo(0, e);
      else tick();
      a = $urandom_range(0, 63);
      ra[0] = 6'(a);
      #1;
      checks++;
      if (bf[0] !== exp_flat(0) || get_cnt(0) != hn[0] || uerr[0] !== e || rp[0] !== mb[0][a] ||
          ls[0] !== 6'(exp_ls(0)) || ld[0] !== 6'(exp_ld(0))) begin
        errors++;
        $display("FAIL random_op%0d: cnt=%0d err=%b rd%0d=%b last=%0d->%0d, need cnt %0d err %b rd %b last %0d->%0d",
                 i, get_cnt(0), uerr[0], a, rp[0], ls[0], ld[0], hn[0], e, mb[0][a], exp_ls(0), exp_ld(0));
      end
    end
  endtask

  task automatic test_init_during;
    int n;
    bit e;
    logic r;
    for (int i = 0; i < 3; i++) do_move(0, 48 + i, 40 + i, 4'b1001);
    ir[0] = 1'b1;
    tick();
    ir[0] = 1'b0;
    mbusy[0] = 1; hn[0] = 0;
    checks++;
    if (get_cnt(0) != 0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL init_clear: cnt=%0d busy=%b, need 0 1", get_cnt(0), busy[0]);
    end
    for (int i = 0; i < 5; i++) tick();
    r = rdy[0];
    do_move(0, 52, 36, 4'b1001);
    do_undo(0, e);
    checks++;
    if (r !== 1'b0 || uerr[0] !== 1'b1 || e !== 1'b1) begin
      errors++;
      $display("FAIL busy_reject: ready=%b undo_err=%b, need 0 1", r, uerr[0]);
    end
    ir[0] = 1'b1;
    tick();
    ir[0] = 1'b0;
    n = 0;
    while (busy[0] && n < 200) begin
      tick();
      n++;
    end
    mbusy[0] = 0;
    m_init(0);
    checks++;
    if (n != 64 || bf[0] !== exp_flat(0) || get_cnt(0) != 0 || ls[0] !== 6'd0) begin
      errors++;
      $display("FAIL init_restore: fill %0d cycles cnt=%0d layout_ok=%b, need 64 0 1", n, get_cnt(0), bf[0] === exp_flat(0));
    end
  endtask

  task automatic test_reset_mid_fill;
    int n;
    do_move(1, 8, 24, 4'b0001);
    do_move(1, 62, 45, 4'b1010);
    ir[0] = 1'b1;
    tick();
    ir[0] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (busy[0] !== 1'b1 || busy[1] !== 1'b1 || bf[0] !== '0 || bf[1] !== '0 || ucnt1 !== 3'd0 ||
        ls[1] !== 6'd0 || ld[1] !== 6'd0 || uerr[0] !== 1'b0 || bf2 !== '0) begin
      errors++;
      $display("FAIL reset_mid_fill: busy=%b/%b cnt1=%0d ls1=%0d ld1=%0d, need 1/1 0 0 0 and empty boards",
               busy[0], busy[1], ucnt1, ls[1], ld[1]);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    n = 0;
    while ((busy[0] || busy2) && n < 300) begin
      tick();
      n++;
    end
    m_init(0); m_init(1);
    checks++;
    if (n != 100 || bf[0] !== exp_flat(0) || bf[1] !== exp_flat(1) || get_cnt(1) != 0) begin
      errors++;
      $display("FAIL refill_after_reset: %0d cycles, cnt1=%0d, need 100 0 and start layout", n, get_cnt(1));
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ir[k] = 0; mv[k] = 0; ur[k] = 0; ms[k] = '0; md[k] = '0; mp[k] = '0; ra[k] = '0;
      mbusy[k] = 1; hn[k] = 0;
    end
    depth[0] = 16; depth[1] = 4;
    ir2 = 0; mv2 = 0; ur2 = 0; ms2 = '0; md2 = '0; mp2 = '0; ra2 = '0;
    test_reset();
    test_commit();
    test_capture_undo();
    test_depth4();
    test_move_beats_undo();
    test_random();
    test_init_during();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
